// File: rtl/gcd_controller.sv
`timescale 1ns/1ps
// gcd_controller
// Control FSM for a subtractive GCD datapath. The datapath holds X and Y
// registers and reports X != Y and X < Y. This block sequences the loads:
// it loads the operands, subtracts the smaller register from the larger
// until they are equal, then latches the result into d_o.
//
// Optional feature: define GCD_TIMEOUT_EN to add an 8-bit iteration counter.
// After 255 subtract cycles without convergence, the FSM ends in DONE with
// err=1 and does not pulse d_o_ld. Without the macro, err is tied to 0 and
// the loop has no bound.
//
// Ports:
//   clk      - clock; all state changes on the rising edge
//   reset    - asynchronous active-high reset, forces IDLE
//   go       - start request, level handshake (read only in IDLE/DONE)
//   x_neq_y  - datapath flag X != Y (read only in CHECK)
//   x_lt_y   - datapath flag X <  Y (read only in CHECK)
//   x_ld     - X register load enable
//   y_ld     - Y register load enable
//   x_sel    - X mux select: 0 = x_i, 1 = X-Y
//   y_sel    - Y mux select: 0 = y_i, 1 = Y-X
//   d_o_ld   - result register load enable
//   enable   - d_o output enable
//   busy     - operation in progress
//   done     - result valid
//   err      - timeout flag (GCD_TIMEOUT_EN only, else 0)
module gcd_controller (
    input  logic clk,
    input  logic reset,
    input  logic go,
    input  logic x_neq_y,
    input  logic x_lt_y,
    output logic x_ld,
    output logic y_ld,
    output logic x_sel,
    output logic y_sel,
    output logic d_o_ld,
    output logic enable,
    output logic busy,
    output logic done,
    output logic err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        CHECK = 3'd2,
        UPDX  = 3'd3,
        UPDY  = 3'd4,
        LATCH = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   timeout_hit;

`ifdef GCD_TIMEOUT_EN
    logic [7:0] iter_cnt;
    logic       err_q;

    // The loop is abandoned only while the registers still differ. A run
    // that converges exactly on the 255th update still ends normally.
    assign timeout_hit = (state == CHECK) && x_neq_y && (iter_cnt == 8'hFF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            iter_cnt <= 8'd0;
        end else if (state == INIT) begin
            iter_cnt <= 8'd0;
        end else if (((state == UPDX) || (state == UPDY)) && (iter_cnt != 8'hFF)) begin
            iter_cnt <= iter_cnt + 8'd1;
        end
    end

    // err marks a DONE that was reached by timeout. It is set on the edge
    // that enters DONE and cleared on the edge that leaves it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end else if (state_nxt != DONE) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        x_ld      = 1'b0;
        y_ld      = 1'b0;
        x_sel     = 1'b0;
        y_sel     = 1'b0;
        d_o_ld    = 1'b0;
        enable    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (go) state_nxt = INIT;
            end
            INIT: begin
                x_ld      = 1'b1;
                y_ld      = 1'b1;
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (!x_neq_y)        state_nxt = LATCH;
                else if (timeout_hit) state_nxt = DONE;
                else if (x_lt_y)     state_nxt = UPDY;
                else                 state_nxt = UPDX;
            end
            UPDX: begin
                x_ld      = 1'b1;
                x_sel     = 1'b1;
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            UPDY: begin
                y_ld      = 1'b1;
                y_sel     = 1'b1;
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            LATCH: begin
                d_o_ld    = 1'b1;
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done   = 1'b1;
                enable = 1'b1;
                // A restart requires go to drop first.
                if (!go) state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gcd_controller.sv
`timescale 1ns/1ps
// tb_gcd_controller
// Self-checking bench for gcd_controller. The bench holds the X/Y/d_o
// datapath that the controller drives. It also holds a reference model that
// plans each transaction's cycle-by-cycle output vectors from the subtractive
// Euclid algorithm. A compare process checks the DUT outputs against the
// planned vectors on every falling edge.
module tb_gcd_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic go = 1'b0;
    logic x_neq_y, x_lt_y;
    logic x_ld, y_ld, x_sel, y_sel, d_o_ld, enable, busy, done, err;

    gcd_controller dut (
        .clk(clk), .reset(reset), .go(go), .x_neq_y(x_neq_y), .x_lt_y(x_lt_y),
        .x_ld(x_ld), .y_ld(y_ld), .x_sel(x_sel), .y_sel(y_sel), .d_o_ld(d_o_ld),
        .enable(enable), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

`ifdef GCD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    // {x_ld, y_ld, x_sel, y_sel, d_o_ld, enable, busy, done, err}
    localparam logic [8:0] V_IDLE     = 9'b000000000;
    localparam logic [8:0] V_INIT     = 9'b110000100;
    localparam logic [8:0] V_CHECK    = 9'b000000100;
    localparam logic [8:0] V_UPDX     = 9'b101000100;
    localparam logic [8:0] V_UPDY     = 9'b010100100;
    localparam logic [8:0] V_LATCH    = 9'b000010100;
    localparam logic [8:0] V_DONE     = 9'b000001010;
    localparam logic [8:0] V_DONE_ERR = 9'b000001011;

    logic [8:0] outv;
    assign outv = {x_ld, y_ld, x_sel, y_sel, d_o_ld, enable, busy, done, err};

    // Datapath that the controller drives
    logic [7:0] xi = 8'd0, yi = 8'd0;
    logic [7:0] xr = 8'd0, yr = 8'd0, d_o = 8'd0;
    int dold_cnt = 0;
    assign x_neq_y = (xr != yr);
    assign x_lt_y  = (xr < yr);

    always @(posedge clk) begin
        if (x_ld) xr <= x_sel ? (xr - yr) : xi;
        if (y_ld) yr <= y_sel ? (yr - xr) : yi;
        if (d_o_ld) begin
            d_o <= xr;
            dold_cnt = dold_cnt + 1;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    logic [8:0] exp_q[$];
    logic [8:0] plan[$];

    always @(negedge clk) begin : cmp
        logic [8:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("outputs", {23'd0, outv}, {23'd0, e});
        end
    end

    // Plans the output vectors for one transaction, from INIT to DONE.
    function automatic void build(input logic [7:0] a_in, input logic [7:0] b_in,
                                  output logic [7:0] g, output bit to);
        int a, b, upd;
        a = a_in; b = b_in; upd = 0; to = 1'b0;
        plan.delete();
        plan.push_back(V_INIT);
        while (a != b) begin
            if (TO_EN && upd == 255) begin
                to = 1'b1;
                break;
            end
            plan.push_back(V_CHECK);
            if (a < b) begin plan.push_back(V_UPDY); b = b - a; end
            else       begin plan.push_back(V_UPDX); a = a - b; end
            upd++;
        end
        plan.push_back(V_CHECK);
        if (to) begin
            plan.push_back(V_DONE_ERR);
        end else begin
            plan.push_back(V_LATCH);
            plan.push_back(V_DONE);
        end
        g = a[7:0];
    endfunction

    // Runs one transaction starting just after a rising edge with the FSM idle.
    // go is randomised while busy (it must be ignored there). go is held high
    // for `hold` extra DONE cycles and then dropped.
    task automatic run_gcd(input logic [7:0] a, input logic [7:0] b, input int hold,
                           output logic [7:0] g);
        bit to;
        int n;
        build(a, b, g, to);
        n = plan.size();
        repeat (hold) plan.push_back(to ? V_DONE_ERR : V_DONE);
        plan.push_back(V_IDLE);
        dold_cnt = 0;
        xi = a; yi = b; go = 1'b1;
        for (int k = 1; k <= n + hold + 1; k++) begin
            @(posedge clk);
            exp_q.push_back(plan[k-1]);
            #1;
            if (k < n)             go = 1'($urandom_range(0, 1));
            else if (k < n + hold) go = 1'b1;
            else                   go = 1'b0;
        end
        chk("d_o_ld_pulses", dold_cnt, to ? 0 : 1);
        if (!to) chk("gcd_result", {24'd0, d_o}, {24'd0, g});
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            exp_q.push_back(V_IDLE);
            #1;
        end
    endtask

    // Called just after a rising edge. Reset is raised mid-cycle and must
    // clear the outputs before the next clock edge.
    task automatic async_reset_now();
        #2 reset = 1'b1;
        #1 chk("rst_async_outs", {23'd0, outv}, 32'd0);
        go = 1'b0;
        @(posedge clk);
        #1 chk("rst_held_outs", {23'd0, outv}, 32'd0);
        reset = 1'b0;
        #1 chk("rst_release_outs", {23'd0, outv}, 32'd0);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin : main
        logic [7:0] g;
        bit found;
        bit err_seen;

        #3 chk("reset_outs", {23'd0, outv}, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle_cycles(3);

        // Model pins: hand-computed sequences and results
        build(8'd12, 8'd8, g, found);
        chk("plan_len_12_8", plan.size(), 8);
        build(8'd9, 8'd9, g, found);
        chk("plan_len_9_9", plan.size(), 4);

        run_gcd(8'd12, 8'd8, 0, g);
        chk("lit_gcd_12_8", {24'd0, d_o}, 32'd4);
        idle_cycles(2);
        run_gcd(8'd9, 8'd9, 3, g);
        chk("lit_gcd_9_9", {24'd0, d_o}, 32'd9);
        idle_cycles(1);
        run_gcd(8'd255, 8'd1, 1, g);
        chk("lit_gcd_255_1", {24'd0, d_o}, 32'd1);

        // Randomised transactions
        for (int r = 0; r < 24; r++) begin
            logic [7:0] a, b;
            if (r < 20) begin
                a = 8'($urandom_range(1, 48));
                b = 8'($urandom_range(1, 48));
            end else begin
                a = 8'($urandom_range(1, 255));
                b = 8'($urandom_range(1, 255));
            end
            run_gcd(a, b, $urandom_range(0, 3), g);
            idle_cycles($urandom_range(0, 2));
        end

        // Asynchronous reset during a Y update, then a fresh transaction
        idle_cycles(1);
        xi = 8'd1; yi = 8'd255; go = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            @(posedge clk); #1;
            if (outv == V_UPDY) found = 1'b1;
        end
        chk("reach_updy", {31'd0, found}, 32'd1);
        async_reset_now();
        idle_cycles(2);
        run_gcd(8'd6, 8'd4, 1, g);
        chk("lit_gcd_6_4", {24'd0, d_o}, 32'd2);
        idle_cycles(1);

        // Zero operand: timeout when built in, otherwise no termination
        if (TO_EN) begin
            run_gcd(8'd0, 8'd5, 2, g);
            idle_cycles(1);
        end else begin
            xi = 8'd0; yi = 8'd5; go = 1'b1;
            err_seen = 1'b0;
            for (int k = 0; k < 600; k++) begin
                @(posedge clk); #1;
                go = 1'($urandom_range(0, 1));
                if (err !== 1'b0) err_seen = 1'b1;
            end
            chk("zero_still_busy", {31'd0, busy}, 32'd1);
            chk("zero_err_low", {31'd0, err_seen}, 32'd0);
            async_reset_now();
            idle_cycles(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
